// File: rtl/spy_path_sampler.sv
// Path-delay sampler: toggles a delay-chain input, then counts clk cycles until the
// synchronized chain output shows the new level, accumulating results over a run of trials.
module spy_path_sampler #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 200,
    parameter int SETTLE_CYC  = 4,
    parameter bit INVERTING   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  trials,
    input  logic        path_result,
    output logic        path_input,
    output logic        busy,
    output logic        done,
    output logic [7:0]  last_delay,
    output logic [15:0] delay_sum,
    output logic [7:0]  fail_count
);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, SETTLE, DONE} state_t;

    localparam logic [7:0] TIMEOUT_C     = 8'(TIMEOUT);
    localparam logic [7:0] SETTLE_LAST_C = 8'(SETTLE_CYC - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   path_input_q, path_input_d;
    logic                   expected_q, expected_d;
    logic [7:0]             trials_q, trials_d;
    logic [7:0]             trial_cnt_q, trial_cnt_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [7:0]             last_delay_q, last_delay_d;
    logic [15:0]            delay_sum_q, delay_sum_d;
    logic [7:0]             fail_count_q, fail_count_d;

    logic                   res_s;
    logic [16:0]            sum_ext;

    // path_result is asynchronous; only the last synchronizer stage is ever observed.
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], path_result};
    assign res_s   = sync_q[SYNC_STAGES-1];
    assign sum_ext = {1'b0, delay_sum_q} + {9'b0, cnt_q};

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        path_input_d = path_input_q;
        expected_d   = expected_q;
        trials_d     = trials_q;
        trial_cnt_d  = trial_cnt_q;
        cnt_d        = cnt_q;
        last_delay_d = last_delay_q;
        delay_sum_d  = delay_sum_q;
        fail_count_d = fail_count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    trials_d     = trials;
                    trial_cnt_d  = 8'd0;
                    cnt_d        = 8'd0;
                    last_delay_d = 8'd0;
                    delay_sum_d  = 16'd0;
                    fail_count_d = 8'd0;
                    state_d      = (trials != 8'd0) ? LAUNCH : DONE;
                end
            end
            LAUNCH: begin
                path_input_d = ~path_input_q;
                expected_d   = ~path_input_q ^ INVERTING;
                cnt_d        = 8'd0;
                state_d      = WAIT;
            end
            WAIT: begin
                // A match wins over a timeout landing in the same cycle.
                if (res_s == expected_q) begin
                    last_delay_d = cnt_q;
                    delay_sum_d  = sum_ext[16] ? 16'hFFFF : sum_ext[15:0];
                    cnt_d        = 8'd0;
                    state_d      = SETTLE;
                end else if (cnt_q == TIMEOUT_C) begin
                    last_delay_d = TIMEOUT_C;
                    fail_count_d = (fail_count_q == 8'hFF) ? 8'hFF : fail_count_q + 8'd1;
                    cnt_d        = 8'd0;
                    state_d      = SETTLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST_C) begin
                    trial_cnt_d = trial_cnt_q + 8'd1;
                    cnt_d       = 8'd0;
                    state_d     = (trial_cnt_d == trials_q) ? DONE : LAUNCH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            path_input_q <= 1'b0;
            expected_q   <= 1'b0;
            trials_q     <= 8'd0;
            trial_cnt_q  <= 8'd0;
            cnt_q        <= 8'd0;
            last_delay_q <= 8'd0;
            delay_sum_q  <= 16'd0;
            fail_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            path_input_q <= path_input_d;
            expected_q   <= expected_d;
            trials_q     <= trials_d;
            trial_cnt_q  <= trial_cnt_d;
            cnt_q        <= cnt_d;
            last_delay_q <= last_delay_d;
            delay_sum_q  <= delay_sum_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign path_input = path_input_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign last_delay = last_delay_q;
    assign delay_sum  = delay_sum_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_spy_path_sampler.sv
// Directed bench for spy_path_sampler: loopback, 5-cycle delay chain and stuck-path models
// driven from a vector table, plus hand-written reset and start-while-busy sequences.
module tb_spy_path_sampler;

    typedef enum logic [1:0] {M_LOOP, M_DLY, M_STUCK} mode_t;

    typedef struct {
        mode_t       mode;
        logic [7:0]  n_trials;
        logic [7:0]  exp_last;
        logic [15:0] exp_sum;
        logic [7:0]  exp_fail;
        logic        exp_pin;
        int          exp_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  trials;
    logic        path_result;
    logic        path_input;
    logic        busy;
    logic        done;
    logic [7:0]  last_delay;
    logic [15:0] delay_sum;
    logic [7:0]  fail_count;

    mode_t       mode = M_STUCK;
    logic [4:0]  dly;
    int          n_checks = 0;
    int          n_errors = 0;
    vec_t        vecs[3];

    spy_path_sampler #(
        .SYNC_STAGES(2),
        .TIMEOUT    (10),
        .SETTLE_CYC (4),
        .INVERTING  (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .trials     (trials),
        .path_result(path_result),
        .path_input (path_input),
        .busy       (busy),
        .done       (done),
        .last_delay (last_delay),
        .delay_sum  (delay_sum),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    // Delay-chain model: path_result reproduces path_input five clk cycles later.
    always @(posedge clk) dly <= {dly[3:0], path_input};

    always_comb begin
        case (mode)
            M_LOOP:  path_result = path_input;
            M_DLY:   path_result = dly[4];
            default: path_result = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Pulses start, then counts busy cycles and done pulses until the block is idle again.
    task automatic run(input logic [7:0] n, output int busy_cyc, output int done_cnt,
                       output bit timed_out);
        busy_cyc  = 0;
        done_cnt  = 0;
        timed_out = 1'b1;
        @(negedge clk);
        start  = 1'b1;
        trials = n;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            busy_cyc++;
            if (done) done_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int  bc;
        int  dc;
        bit  to;
        bit  seen;

        vecs[0] = '{M_LOOP, 8'd0, 8'd0, 16'd0, 8'd0, 1'b0, 1};
        vecs[1] = '{M_LOOP, 8'd3, 8'd2, 16'd6, 8'd0, 1'b1, 25};
        vecs[2] = '{M_DLY,  8'd4, 8'd7, 16'd28, 8'd0, 1'b1, 53};

        rst    = 1'b1;
        start  = 1'b0;
        trials = 8'd0;
        idle_cycles(3);
        check("reset path_input", 32'(path_input), 32'd0);
        check("reset busy",       32'(busy),       32'd0);
        check("reset done",       32'(done),       32'd0);
        check("reset last_delay", 32'(last_delay), 32'd0);
        check("reset delay_sum",  32'(delay_sum),  32'd0);
        check("reset fail_count", 32'(fail_count), 32'd0);
        rst = 1'b0;
        idle_cycles(2);

        for (int v = 0; v < 3; v++) begin
            mode = vecs[v].mode;
            idle_cycles(10);
            run(vecs[v].n_trials, bc, dc, to);
            check($sformatf("vec%0d timeout", v),    32'(to),         32'd0);
            check($sformatf("vec%0d busy_cyc", v),   32'(bc),         32'(vecs[v].exp_busy));
            check($sformatf("vec%0d done_cnt", v),   32'(dc),         32'd1);
            check($sformatf("vec%0d last_delay", v), 32'(last_delay), 32'(vecs[v].exp_last));
            check($sformatf("vec%0d delay_sum", v),  32'(delay_sum),  32'(vecs[v].exp_sum));
            check($sformatf("vec%0d fail_count", v), 32'(fail_count), 32'(vecs[v].exp_fail));
            check($sformatf("vec%0d path_input", v), 32'(path_input), 32'(vecs[v].exp_pin));
        end
        idle_cycles(5);
        check("idle hold delay_sum", 32'(delay_sum), 32'd28);

        // Stuck path: first trial times out, second matches on the stale low level.
        mode = M_STUCK;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset2 path_input", 32'(path_input), 32'd0);
        check("reset2 delay_sum",  32'(delay_sum),  32'd0);
        idle_cycles(3);
        start  = 1'b1;
        trials = 8'd2;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (fail_count == 8'd1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("stuck trial1 timeout seen", 32'(seen),       32'd1);
        check("stuck trial1 last_delay",   32'(last_delay), 32'd10);
        check("stuck trial1 delay_sum",    32'(delay_sum),  32'd0);
        check("stuck trial1 busy",         32'(busy),       32'd1);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!busy) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("stuck finished",   32'(seen),       32'd1);
        check("stuck last_delay", 32'(last_delay), 32'd0);
        check("stuck fail_count", 32'(fail_count), 32'd1);
        check("stuck delay_sum",  32'(delay_sum),  32'd0);
        check("stuck path_input", 32'(path_input), 32'd0);

        // Reset in the WAIT of the second trial must abort the run for good.
        mode = M_DLY;
        idle_cycles(10);
        start  = 1'b1;
        trials = 8'd4;
        @(negedge clk);
        start = 1'b0;
        idle_cycles(16);
        check("midrun busy",       32'(busy),       32'd1);
        check("midrun last_delay", 32'(last_delay), 32'd7);
        check("midrun delay_sum",  32'(delay_sum),  32'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy",       32'(busy),       32'd0);
        check("abort done",       32'(done),       32'd0);
        check("abort path_input", 32'(path_input), 32'd0);
        check("abort last_delay", 32'(last_delay), 32'd0);
        check("abort delay_sum",  32'(delay_sum),  32'd0);
        check("abort fail_count", 32'(fail_count), 32'd0);
        idle_cycles(30);
        check("no resume busy",      32'(busy),      32'd0);
        check("no resume delay_sum", 32'(delay_sum), 32'd0);

        // Start pulses during a run are ignored: run length and results are unchanged.
        mode = M_LOOP;
        idle_cycles(5);
        start  = 1'b1;
        trials = 8'd3;
        @(negedge clk);
        start = 1'b0;
        bc    = 0;
        dc    = 0;
        to    = 1'b1;
        for (int c = 0; c < 500; c++) begin
            if (!busy) begin
                start = 1'b0;
                to    = 1'b0;
                break;
            end
            bc++;
            if (done) dc++;
            start  = (c % 3 == 0);
            trials = 8'd9;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy-start timeout",    32'(to),         32'd0);
        check("busy-start busy_cyc",   32'(bc),         32'd25);
        check("busy-start done_cnt",   32'(dc),         32'd1);
        check("busy-start last_delay", 32'(last_delay), 32'd2);
        check("busy-start delay_sum",  32'(delay_sum),  32'd6);
        idle_cycles(5);
        check("busy-start stays idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spy_path_sampler.md
SPY_PATH_SAMPLER -- requirements
Module: spy_path_sampler

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on path_result (legal range 2..4).
REQ-002 SHALL have parameter TIMEOUT, default 200: maximum number of WAIT cycles per trial (legal range 1..255).
REQ-003 SHALL have parameter SETTLE_CYC, default 4: number of idle cycles between trials (legal range 1..255).
REQ-004 SHALL have parameter INVERTING, default 0: chain polarity; 1 means the chain output is the complement of its input.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: request a measurement run; sampled only in IDLE.
REQ-008 SHALL have port trials, input, 8 bits: number of launch/capture trials; latched when start is accepted.
REQ-009 SHALL have port path_result, input, 1 bit: delay-chain output; asynchronous to clk.
REQ-010 SHALL have port path_input, output, 1 bit, registered: drives the delay-chain input.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-013 SHALL have port last_delay, output, 8 bits: measured cycle count of the most recent trial.
REQ-014 SHALL have port delay_sum, output, 16 bits: sum of last_delay over successful trials; saturates at 0xFFFF.
REQ-015 SHALL have port fail_count, output, 8 bits: number of timed-out trials; saturates at 0xFF.

Function
REQ-016 SHALL pass path_result through SYNC_STAGES flops; only the last flop output (res_s) is used.
REQ-017 SHALL implement FSM states IDLE, LAUNCH, WAIT, SETTLE, DONE.
REQ-018 IDLE with start=1 SHALL latch trials and clear last_delay, delay_sum, fail_count and the trial counter.
- Next state is LAUNCH when trials != 0.
- Next state is DONE when trials == 0.
REQ-019 start SHALL be ignored in every state except IDLE.
REQ-020 LAUNCH SHALL last one cycle.
- Toggles path_input at the end of the cycle.
- Sets expected = new path_input XOR INVERTING.
- Clears the cycle counter to 0.
- Next state is WAIT.
REQ-021 WAIT SHALL increment the cycle counter by one per cycle, the first WAIT cycle being count 0.
REQ-022 WAIT with res_s == expected SHALL:
- load last_delay with the current count;
- add the current count to delay_sum, saturating;
- move to SETTLE.
REQ-023 WAIT with count == TIMEOUT and no match SHALL:
- load last_delay with TIMEOUT;
- increment fail_count, saturating;
- leave delay_sum unchanged;
- move to SETTLE.
REQ-024 If a match and the timeout occur in the same cycle, the match SHALL take priority.
REQ-025 With path_result tied directly to path_input, last_delay SHALL equal SYNC_STAGES.
REQ-026 SETTLE SHALL hold for SETTLE_CYC cycles, then increment the trial counter.
- Next state is DONE when the trial counter equals the latched trials.
- Otherwise next state is LAUNCH.
REQ-027 After a timed-out trial, the next trial SHALL proceed normally; a stale res_s equal to the new expected value counts as a match.
REQ-028 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-029 last_delay, delay_sum and fail_count SHALL hold their values in IDLE until the next accepted start.
REQ-030 path_input SHALL NOT change in any state other than LAUNCH.

Reset
REQ-031 rst=1 at a clock edge SHALL force the block to its reset state in every state, including mid-run.
- State is IDLE.
- path_input, busy, done, last_delay, delay_sum, fail_count, the counters and all synchronizer flops are 0.
REQ-032 A run SHALL NOT resume after reset; a new start is required.

Verification
REQ-033 Loopback: path_result = path_input, SYNC_STAGES=2, trials=3 -> last_delay=2, delay_sum=6, fail_count=0, done pulses once, path_input=1 at the end.
REQ-034 Delay model: path_result follows path_input after 5 clk cycles, trials=4 -> last_delay=7, delay_sum=28, fail_count=0.
REQ-035 Stuck path: path_result=0, INVERTING=0, TIMEOUT=10, trials=2 -> trial 1 times out, fail_count=1 after trial 1; trial 2 matches on the stale value with last_delay=0; final fail_count=1, delay_sum=0.
REQ-036 trials=0 with start -> busy high for one cycle, done pulses, path_input never toggles, all results 0.
REQ-037 Reset mid-WAIT, then start pulses while busy -> all outputs 0 and IDLE after reset; starts during a later run do not restart or extend it.
